mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide sequencer for the E stage of the 5-stage MIPS pipeline. It accepts the MDU_op decoded by the per-stage controller and owns the HI/LO registers.
- It models MULT/DIV latency with a countdown, handles MTHI/MTLO writes and suppresses issue on exception/interrupt request.
- It generates the D-stage stall for any md/mf instruction while an operation is pending.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (2..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (2..15)

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- start  input  1  E-stage instruction is an MDU op (valid qualifier for MDU_op)
- MDU_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
- A  input  32  forwarded rs value (E stage)
- B  input  32  forwarded rt value (E stage)
- req  input  1  exception/interrupt flush this cycle; blocks issue
- D_md  input  1  D-stage instruction is md (mult/div/mthi/mtlo) or mf (mfhi/mflo)
- busy  output  1  operation in flight
- stall  output  1  D-stage stall request
- HI  output  32  architectural HI
- LO  output  32  architectural LO

Behaviour:
- Reset: state IDLE, counter 0, busy 0, HI 0, LO 0, pending result regs 0. Reset mid-operation aborts the op; HI/LO go to 0 and no late commit occurs.
- issue = start & ~req & ~busy & (MDU_op <= 5). start while busy is ignored: no state change, HI/LO untouched. Upstream stall makes this unreachable in a correct pipeline; the bench checks it anyway.
- FSM states IDLE, MUL, DIV:
  - IDLE + issue with op 0/1: compute the 64-bit product into pending {hi,lo}, load counter = MULT_CYCLES, go to MUL.
  - IDLE + issue with op 2/3: compute quotient to pending lo and remainder to pending hi, load counter = DIV_CYCLES, go to DIV.
  - IDLE + issue with op 4: HI <= A at that edge, stay IDLE. Op 5: LO <= A, stay IDLE. These take no busy cycles.
  - MUL/DIV: counter decrements each edge. On the edge where counter goes 1->0, HI/LO <= pending and the FSM returns to IDLE.
- Latency: for a MULT/DIV issued in cycle t, busy=1 in cycles t+1 .. t+N (N = MULT_CYCLES or DIV_CYCLES). HI/LO hold the new value from cycle t+N+1, the first cycle busy=0.
- busy is registered: busy = (state != IDLE).
- stall is combinational: stall = D_md & (busy | (start & ~req & MDU_op <= 3)). It covers the issue cycle itself.
- Arithmetic:
  - MULT: signed 32x32->64.
  - MULTU: unsigned 32x32->64.
  - DIV: signed; quotient truncated toward zero; remainder takes the sign of the dividend.
  - DIVU: unsigned.
  - 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
- Divide by zero (DIV/DIVU with B=0): full latency is still spent; HI/LO are left unchanged at commit.
- req: blocks issue and MTHI/MTLO in that cycle. An op already in MUL/DIV is not cancelled and commits normally, matching the MIPS rule that an issued mult/div completes.
- Back-to-back: a new issue is accepted in the cycle busy first reads 0. HI/LO then hold the previous result until the new commit.

Test Plan:
- reset, then MULT A=0xFFFFFFFE B=3 in cycle 0: busy=1 in cycles 1..5, stall=1 with D_md=1 in cycles 0..5; from cycle 6 HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- DIVU A=100 B=7: busy for 10 cycles, then LO=14 (0x0000000E), HI=2. DIV A=-7 (0xFFFFFFF9) B=2: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MTHI A=0x12345678, next cycle MTLO A=0x9ABCDEF0: busy never asserts; HI/LO update at the respective edges. Same MTHI with req=1 leaves HI unchanged.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, with start asserted again (DIV) in cycle 3: the second start is ignored; at commit HI=0xFFFFFFFE, LO=0x00000001.
- DIV B=0 after HI=5, LO=6: busy 10 cycles, then HI=5, LO=6. Signed 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
- reset asserted in cycle 3 of a DIV: next cycle busy=0, HI=LO=0, and no commit in the cycles where the DIV would have finished. A separate run with req=1 in the issue cycle of MULT: no busy, HI/LO unchanged.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer for the E stage: owns HI/LO, models
// MULT/DIV latency with a countdown and raises the D-stage stall for md/mf ops.
module mdu_sequencer #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  MDU_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        req,
   input  logic        D_md,
   output logic        busy,
   output logic        stall,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } state_t;

   localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

   state_t      state_r, state_nx_s;
   logic [3:0]  count_r, count_nx_s;
   logic [31:0] pend_hi_r, pend_hi_nx_s;
   logic [31:0] pend_lo_r, pend_lo_nx_s;
   logic        div0_r, div0_nx_s;
   logic [31:0] hi_r, hi_nx_s;
   logic [31:0] lo_r, lo_nx_s;
   logic        busy_r;

   logic        issue_s;
   logic [63:0] mul_s_s;
   logic [63:0] mul_u_s;
   logic [31:0] abs_a_s, abs_b_s;
   logic [31:0] uq_s, ur_s;
   logic [31:0] sq_s, sr_s;
   logic [31:0] dq_s, dr_s;

   assign issue_s = start & ~req & ~busy_r & (MDU_op <= 3'd5);

   // Products and quotients for the operation being issued this cycle
   always_comb begin
      mul_s_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
      mul_u_s = {32'd0, A} * {32'd0, B};
      abs_a_s = A[31] ? (32'd0 - A) : A;
      abs_b_s = B[31] ? (32'd0 - B) : B;
      // Guarded against B=0 so no X/undefined value reaches the pending regs;
      // a zero divisor never commits anyway.
      if (B != 32'd0) begin
         uq_s = abs_a_s / abs_b_s;
         ur_s = abs_a_s % abs_b_s;
         dq_s = A / B;
         dr_s = A % B;
      end else begin
         uq_s = 32'd0;
         ur_s = 32'd0;
         dq_s = 32'd0;
         dr_s = 32'd0;
      end
      // Magnitude division then sign fix-up; 0x80000000 / -1 falls out as 0x80000000 rem 0
      sq_s = (A[31] ^ B[31]) ? (32'd0 - uq_s) : uq_s;
      sr_s = A[31] ? (32'd0 - ur_s) : ur_s;
   end

   // Next-state, countdown and HI/LO update logic
   always_comb begin
      state_nx_s   = state_r;
      count_nx_s   = count_r;
      pend_hi_nx_s = pend_hi_r;
      pend_lo_nx_s = pend_lo_r;
      div0_nx_s    = div0_r;
      hi_nx_s      = hi_r;
      lo_nx_s      = lo_r;
      case (state_r)
         IDLE: begin
            if (issue_s) begin
               case (MDU_op)
                  3'd0: begin
                     {pend_hi_nx_s, pend_lo_nx_s} = mul_s_s;
                     div0_nx_s  = 1'b0;
                     count_nx_s = MULT_N;
                     state_nx_s = MUL;
                  end
                  3'd1: begin
                     {pend_hi_nx_s, pend_lo_nx_s} = mul_u_s;
                     div0_nx_s  = 1'b0;
                     count_nx_s = MULT_N;
                     state_nx_s = MUL;
                  end
                  3'd2: begin
                     pend_lo_nx_s = sq_s;
                     pend_hi_nx_s = sr_s;
                     div0_nx_s    = (B == 32'd0);
                     count_nx_s   = DIV_N;
                     state_nx_s   = DIV;
                  end
                  3'd3: begin
                     pend_lo_nx_s = dq_s;
                     pend_hi_nx_s = dr_s;
                     div0_nx_s    = (B == 32'd0);
                     count_nx_s   = DIV_N;
                     state_nx_s   = DIV;
                  end
                  3'd4: hi_nx_s = A;
                  3'd5: lo_nx_s = A;
                  default: state_nx_s = IDLE;
               endcase
            end else begin
               state_nx_s = IDLE;
            end
         end
         MUL, DIV: begin
            count_nx_s = count_r - 4'd1;
            if (count_r == 4'd1) begin
               state_nx_s = IDLE;
               if (!div0_r) begin
                  hi_nx_s = pend_hi_r;
                  lo_nx_s = pend_lo_r;
               end else begin
                  hi_nx_s = hi_r;
               end
            end else begin
               state_nx_s = state_r;
            end
         end
         default: begin
            state_nx_s = IDLE;
            count_nx_s = 4'd0;
         end
      endcase
   end

   // State, pending result and architectural HI/LO registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         count_r   <= 4'd0;
         pend_hi_r <= 32'd0;
         pend_lo_r <= 32'd0;
         div0_r    <= 1'b0;
         hi_r      <= 32'd0;
         lo_r      <= 32'd0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_nx_s;
         count_r   <= count_nx_s;
         pend_hi_r <= pend_hi_nx_s;
         pend_lo_r <= pend_lo_nx_s;
         div0_r    <= div0_nx_s;
         hi_r      <= hi_nx_s;
         lo_r      <= lo_nx_s;
         busy_r    <= (state_nx_s != IDLE);
      end
   end

   // Stall covers the issue cycle itself as well as every busy cycle
   assign stall = D_md & (busy_r | (start & ~req & (MDU_op <= 3'd3)));
   assign busy  = busy_r;
   assign HI    = hi_r;
   assign LO    = lo_r;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: hand-computed HI/LO results, latency,
// stall, req blocking, ignored start while busy and reset abort.
module tb_mdu_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  MDU_op;
   logic [31:0] A;
   logic [31:0] B;
   logic        req;
   logic        D_md;
   logic        busy;
   logic        stall;
   logic [31:0] HI;
   logic [31:0] LO;

   int total_cnt;
   int bad_cnt;

   mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .MDU_op (MDU_op),
      .A      (A),
      .B      (B),
      .req    (req),
      .D_md   (D_md),
      .busy   (busy),
      .stall  (stall),
      .HI     (HI),
      .LO     (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      if (obs !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // inputs change 1ns after the rising edge, outputs are sampled on the falling edge
   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic idle_in();
      start  = 1'b0;
      req    = 1'b0;
      D_md   = 1'b0;
      MDU_op = 3'd7;
      A      = 32'd0;
      B      = 32'd0;
   endtask

   // issue in cycle 0, expect busy in cycles 1..n, return at mid of cycle n+1
   task automatic issue_wait(input string tag, input logic [2:0] op,
                             input logic [31:0] a, input logic [31:0] b, input int n);
      start = 1'b1; MDU_op = op; A = a; B = b;
      mid();
      check({tag, "_busy0"}, {63'd0, busy}, 64'd0);
      next();
      idle_in();
      for (int i = 1; i <= n; i++) begin
         mid();
         check({tag, "_busy"}, {63'd0, busy}, 64'd1);
         next();
      end
      mid();
      check({tag, "_done"}, {63'd0, busy}, 64'd0);
   endtask

   task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
      start = 1'b1; MDU_op = 3'd4; A = h;
      next();
      MDU_op = 3'd5; A = l;
      next();
      idle_in();
   endtask

   initial begin
      total_cnt = 0;
      bad_cnt   = 0;
      idle_in();
      reset = 1'b1;
      next();
      next();
      reset = 1'b0;
      mid();
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_hilo", {HI, LO}, 64'd0);
      next();

      // MULT -2 * 3 with D_md held: stall cycles 0..5, busy cycles 1..5
      start = 1'b1; MDU_op = 3'd0; A = 32'hFFFFFFFE; B = 32'd3; D_md = 1'b1;
      mid();
      check("mult_stall0", {63'd0, stall}, 64'd1);
      check("mult_busy0", {63'd0, busy}, 64'd0);
      next();
      start = 1'b0; MDU_op = 3'd7;
      for (int c = 1; c <= 5; c++) begin
         mid();
         check("mult_busy", {63'd0, busy}, 64'd1);
         check("mult_stall", {63'd0, stall}, 64'd1);
         next();
      end
      mid();
      check("mult_busy6", {63'd0, busy}, 64'd0);
      check("mult_stall6", {63'd0, stall}, 64'd0);
      check("mult_hilo", {HI, LO}, 64'hFFFFFFFF_FFFFFFFA);
      next();
      idle_in();

      issue_wait("divu", 3'd3, 32'd100, 32'd7, 10);
      check("divu_hilo", {HI, LO}, {32'd2, 32'd14});
      next();

      issue_wait("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, 10);
      check("div_neg_hilo", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
      next();

      // MTHI then MTLO: zero latency, busy stays low
      start = 1'b1; MDU_op = 3'd4; A = 32'h12345678;
      mid();
      check("mthi_busy", {63'd0, busy}, 64'd0);
      next();
      MDU_op = 3'd5; A = 32'h9ABCDEF0;
      mid();
      check("mthi_hi", {32'd0, HI}, {32'd0, 32'h12345678});
      check("mtlo_busy", {63'd0, busy}, 64'd0);
      next();
      idle_in();
      mid();
      check("mtlo_lo", {32'd0, LO}, {32'd0, 32'h9ABCDEF0});
      check("mt_busy", {63'd0, busy}, 64'd0);
      next();
      start = 1'b1; MDU_op = 3'd4; A = 32'hDEADBEEF; req = 1'b1;
      next();
      idle_in();
      mid();
      check("mthi_req", {HI, LO}, 64'h12345678_9ABCDEF0);
      next();

      // MULTU with a DIV start in cycle 3 that must be ignored
      start = 1'b1; MDU_op = 3'd1; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
      next();
      idle_in();
      for (int c = 1; c <= 5; c++) begin
         start = (c == 3); MDU_op = 3'd2; A = 32'd10; B = 32'd3;
         mid();
         check("multu_busy", {63'd0, busy}, 64'd1);
         next();
      end
      idle_in();
      mid();
      check("multu_done", {63'd0, busy}, 64'd0);
      check("multu_hilo", {HI, LO}, 64'hFFFFFFFE_00000001);
      next();
      mid();
      check("multu_nodiv", {63'd0, busy}, 64'd0);
      next();

      write_hilo(32'd5, 32'd6);
      issue_wait("div0", 3'd2, 32'd123, 32'd0, 10);
      check("div0_hilo", {HI, LO}, {32'd5, 32'd6});
      next();

      issue_wait("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10);
      check("div_ovf_hilo", {HI, LO}, 64'h00000000_80000000);
      next();

      // reset in cycle 3 of a DIV aborts it with no late commit
      start = 1'b1; MDU_op = 3'd3; A = 32'd100; B = 32'd7;
      next();
      idle_in();
      next();
      next();
      reset = 1'b1;
      next();
      reset = 1'b0;
      mid();
      check("rstdiv_busy", {63'd0, busy}, 64'd0);
      check("rstdiv_hilo", {HI, LO}, 64'd0);
      for (int c = 5; c <= 12; c++) begin
         next();
         mid();
         check("rstdiv_nocommit", {HI, LO}, 64'd0);
      end
      next();

      // req in the MULT issue cycle: no issue, no stall, HI/LO unchanged
      write_hilo(32'h11, 32'h22);
      start = 1'b1; MDU_op = 3'd0; A = 32'd5; B = 32'd7; req = 1'b1; D_md = 1'b1;
      mid();
      check("req_stall", {63'd0, stall}, 64'd0);
      next();
      idle_in();
      for (int c = 1; c <= 6; c++) begin
         mid();
         check("req_busy", {63'd0, busy}, 64'd0);
         next();
      end
      mid();
      check("req_hilo", {HI, LO}, {32'h11, 32'h22});

      // stall needs D_md; MTHI is not a stalling issue
      D_md = 1'b1; start = 1'b1; MDU_op = 3'd4; A = 32'd9;
      mid();
      check("mthi_nostall", {63'd0, stall}, 64'd0);
      next();
      idle_in();

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
